// File: rtl/ram_access_controller.sv
// ram_access_controller: UART image load, CPU process window, RAM result streaming to UART; LOAD_CHECKSUM_EN adds a load-byte checksum
module ram_access_controller #(
  parameter int          IMAGE_BYTES  = 16384,
  parameter logic [15:0] RESULT_BASE  = 16'h0000,
  parameter int          RESULT_BYTES = 16384
) (
  input  logic        MAIN_CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic        RX_VALID,
  input  logic [7:0]  RX_DATA,
  input  logic        CPU_WRITE_EN,
  input  logic [15:0] CPU_ADDRESS,
  input  logic [7:0]  CPU_DATA,
  input  logic        PROCESS_FINISHED,
  input  logic        TX_DONE,
  input  logic [7:0]  RAM_Q,
  output logic [15:0] RAM_ADDRESS,
  output logic [7:0]  RAM_DATA,
  output logic        RAM_WREN,
  output logic        CPU_RUN,
  output logic        TX_START,
  output logic [7:0]  TX_DATA,
  output logic [2:0]  STATE,
  output logic        ALL_DONE,
  output logic [7:0]  CHECKSUM
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    PROCESS  = 3'd2,
    TX_READ  = 3'd3,
    TX_LATCH = 3'd4,
    TX_WAIT  = 3'd5,
    DONE     = 3'd6
  } state_t;
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  tx_data_q;
  logic        tx_start_q, cpu_run_q, all_done_q;
  logic        ld, pr, rd;
  assign ld = state_q == LOAD;
  assign pr = state_q == PROCESS;
  assign rd = state_q == TX_READ || state_q == TX_LATCH;
  // RAM port owner follows the phase: UART loader, CPU, then the transmit reader
  always_comb begin
    RAM_WREN    = ld ? RX_VALID : pr ? CPU_WRITE_EN : 1'b0;
    RAM_DATA    = ld ? RX_DATA : pr ? CPU_DATA : 8'h00;
    RAM_ADDRESS = ld ? cnt_q : pr ? CPU_ADDRESS : rd ? RESULT_BASE + cnt_q : 16'h0000;
  end
  // Run sequencer; TX_START is a one-cycle pulse on entry to TX_WAIT
  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (START) begin
          state_q    <= LOAD;
          cnt_q      <= '0;
          all_done_q <= 1'b0;
        end
        LOAD: if (RX_VALID) begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == 16'(IMAGE_BYTES - 1)) begin
            state_q   <= PROCESS;
            cpu_run_q <= 1'b1;
          end
        end
        PROCESS: if (PROCESS_FINISHED) begin
          state_q   <= TX_READ;
          cnt_q     <= '0;
          cpu_run_q <= 1'b0;
        end
        TX_READ: state_q <= TX_LATCH;
        TX_LATCH: begin
          tx_data_q  <= RAM_Q;
          tx_start_q <= 1'b1;
          state_q    <= TX_WAIT;
        end
        TX_WAIT: if (TX_DONE) begin
          if (cnt_q == 16'(RESULT_BYTES - 1)) begin
            state_q    <= DONE;
            all_done_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
            state_q <= TX_READ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef LOAD_CHECKSUM_EN
  logic [7:0] sum_q;
  // Running modulo-256 sum of every byte accepted in LOAD, cleared when a run starts
  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) sum_q <= 8'h00;
    else if (START && (state_q == IDLE || state_q == DONE)) sum_q <= 8'h00;
    else if (ld && RX_VALID) sum_q <= sum_q + RX_DATA;
  end
  assign CHECKSUM = sum_q;
`else
  assign CHECKSUM = 8'h00;
`endif
  assign STATE    = state_q;
  assign TX_START = tx_start_q;
  assign TX_DATA  = tx_data_q;
  assign CPU_RUN  = cpu_run_q;
  assign ALL_DONE = all_done_q;
endmodule

// File: doc/ram_access_controller.md
RAM_ACCESS_CONTROLLER -- requirements
Module: ram_access_controller

Interface
REQ-001 Parameters SHALL be: IMAGE_BYTES, default 16384, number of bytes loaded from UART into image RAM starting at address 0; RESULT_BASE, default 16'h0000, first RAM address streamed out; RESULT_BYTES, default 16384, number of bytes streamed out.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
MAIN_CLOCK  in  1  sole clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
START  in  1  one-cycle request to begin a load/process/transmit run
RX_VALID  in  1  one-cycle pulse, UART received byte valid
RX_DATA  in  8  received byte
CPU_WRITE_EN  in  1  CPU RAM write enable
CPU_ADDRESS  in  16  CPU RAM address
CPU_DATA  in  8  CPU RAM write data
PROCESS_FINISHED  in  1  CPU done (level)
TX_DONE  in  1  one-cycle pulse, UART finished sending a byte
RAM_Q  in  8  RAM read data, valid one cycle after address presented
RAM_ADDRESS  out  16  muxed RAM address
RAM_DATA  out  8  muxed RAM write data
RAM_WREN  out  1  muxed RAM write enable
CPU_RUN  out  1  CPU enable, high only in PROCESS
TX_START  out  1  one-cycle pulse requesting UART send of TX_DATA
TX_DATA  out  8  byte to transmit, stable from TX_START until TX_DONE
STATE  out  3  current state encoding
ALL_DONE  out  1  high in DONE
CHECKSUM  out  8  modulo-256 sum of loaded bytes

Function
REQ-003 States SHALL be IDLE=0, LOAD=1, PROCESS=2, TX_READ=3, TX_LATCH=4, TX_WAIT=5, DONE=6; STATE reflects the registered state.
REQ-004 IDLE: START moves to LOAD, clearing byte counter and CHECKSUM; START in any state other than IDLE or DONE SHALL be ignored.
REQ-005 LOAD: each RX_VALID SHALL drive RAM_ADDRESS=counter, RAM_DATA=RX_DATA, RAM_WREN=1 combinationally that cycle, then increment the counter; RAM_WREN=0 on cycles without RX_VALID.
REQ-006 LOAD SHALL move to PROCESS on the edge where the RX_VALID for counter IMAGE_BYTES-1 is accepted.
REQ-007 PROCESS: RAM_ADDRESS/RAM_DATA/RAM_WREN SHALL equal CPU_ADDRESS/CPU_DATA/CPU_WRITE_EN combinationally; CPU_RUN=1.
REQ-008 PROCESS SHALL move to TX_READ when PROCESS_FINISHED is sampled high, clearing the counter; CPU_RUN SHALL be 0 from the next cycle.
REQ-009 TX_READ: RAM_ADDRESS=RESULT_BASE+counter (16-bit, wraps modulo 2^16), RAM_WREN=0; next state TX_LATCH.
REQ-010 TX_LATCH: TX_DATA SHALL register RAM_Q and TX_START SHALL pulse high for exactly the first TX_WAIT cycle; next state TX_WAIT.
REQ-011 TX_WAIT: on TX_DONE, if counter=RESULT_BYTES-1 go to DONE, else increment counter and go to TX_READ; TX_DONE arriving the same cycle as TX_START SHALL be accepted.
REQ-012 DONE: ALL_DONE=1, RAM_WREN=0; START SHALL restart at LOAD as from IDLE.
REQ-013 RX_VALID outside LOAD, TX_DONE outside TX_WAIT, PROCESS_FINISHED outside PROCESS SHALL be ignored.
REQ-014 Outside LOAD and PROCESS, RAM_WREN SHALL be 0 in every cycle; RAM_DATA SHALL be 8'h00.
REQ-015 Per-byte latency in transmit: TX_START no later than 2 cycles after entering TX_READ.

Reset
REQ-016 RESET high SHALL asynchronously force state IDLE, counter 0, TX_DATA 8'h00, CHECKSUM 8'h00, TX_START 0, CPU_RUN 0, ALL_DONE 0, RAM_WREN 0, RAM_ADDRESS 16'h0000.
REQ-017 RESET mid-LOAD or mid-transmit SHALL abandon the run; no RAM write or TX_START SHALL occur in the cycle after release unless START/RX_VALID rules then permit.

Configuration
REQ-018 Macro LOAD_CHECKSUM_EN: defined -> CHECKSUM accumulates RX_DATA (mod 256) for every accepted LOAD byte and holds afterwards; undefined -> no accumulator, CHECKSUM tied 8'h00.

Verification (IMAGE_BYTES=4, RESULT_BASE=16'h0010, RESULT_BYTES=2)
REQ-019 START, RX bytes 8'h11,22,33,44 -> writes addr 0..3 with those data, STATE=2 after 4th, CHECKSUM=8'hAA (macro on) / 8'h00 (off).
REQ-020 In PROCESS, CPU_ADDRESS=16'h0010, CPU_DATA=8'h5A, CPU_WRITE_EN=1 -> RAM_ADDRESS=16'h0010, RAM_DATA=8'h5A, RAM_WREN=1 same cycle.
REQ-021 PROCESS_FINISHED=1, RAM_Q model returns 8'h5A/8'hA5 for 0x10/0x11 -> two TX_START pulses with TX_DATA 8'h5A then 8'hA5, each awaited by TX_DONE, then ALL_DONE=1.
REQ-022 RX_VALID during PROCESS and TX_DONE during LOAD -> no RAM_WREN from RX, no counter change.
REQ-023 RESET asserted after 2nd loaded byte -> immediate IDLE, all outputs at reset values; fresh START reloads from address 0.
REQ-024 START while in DONE -> STATE=1, counter 0, next RX byte written to address 0.
